cfg_reg_bank_loader: RTL and testbench

Parametrised configuration-register loader for the multi-camera register BRAM. After reset it fills every channel's register slice with geometry-derived defaults. It then arbitrates host register writes and per-channel default reloads onto the BRAM write port (port B). Register readers keep port A.

---
 rtl/cfg_reg_bank_loader_if.sv | 44 ++++
 rtl/cfg_reg_bank_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_cfg_reg_bank_loader.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_reg_bank_loader_if.sv
// ---------------------------------------------------------------------------
// cfg_reg_bank_loader_if
//
// Host register-write handshake into the configuration register loader.
// A write is transferred on the rising edge where i_wr_valid and o_wr_ready
// are both high (and the loader is clock-enabled). The host must hold
// i_wr_valid and the payload until that edge.
//
// Signals:
//   i_wr_valid  host -> loader  write request
//   o_wr_ready  loader -> host  loader can accept a write
//   i_wr_ch     host -> loader  target channel
//   i_wr_reg    host -> loader  target register within the channel
//   i_wr_data   host -> loader  write data
//
// Modports: master = host side, slave = loader side.
// ---------------------------------------------------------------------------
interface cfg_reg_bank_loader_if #(
    parameter int CH_WIDTH   = 1,
    parameter int REG_WIDTH  = 6,
    parameter int DATA_WIDTH = 25
);
    logic                  i_wr_valid;
    logic                  o_wr_ready;
    logic [CH_WIDTH-1:0]   i_wr_ch;
    logic [REG_WIDTH-1:0]  i_wr_reg;
    logic [DATA_WIDTH-1:0] i_wr_data;

    modport master (
        output i_wr_valid,
        output i_wr_ch,
        output i_wr_reg,
        output i_wr_data,
        input  o_wr_ready
    );

    modport slave (
        input  i_wr_valid,
        input  i_wr_ch,
        input  i_wr_reg,
        input  i_wr_data,
        output o_wr_ready
    );
endinterface

// File: rtl/cfg_reg_bank_loader.sv
// ---------------------------------------------------------------------------
// cfg_reg_bank_loader
//
// Drives the write port (port B) of the multi-camera configuration register
// BRAM. After reset it fills every channel's register slice with defaults
// derived from the camera geometry, then arbitrates host register writes and
// per-channel default reloads onto the write port. Port A belongs to the
// register readers and is not touched here.
//
// Defaults (same for every channel, zero-extended):
//   reg 0 = 2^CAM_PIXEL-1, reg 1 = 2^CAM_LINE-1, all others 0.
// BRAM address = ch*REGS_PER_CH + reg.
//
// Ports:
//   clk           system clock, rising edge
//   i_reset_n     asynchronous active-low reset
//   i_enable      clock enable; nothing advances on edges with i_enable=0
//                 (the BRAM port B enable must be tied to this same signal)
//   i_reload      restore defaults of channel i_reload_ch (honoured in IDLE)
//   i_reload_ch   channel to reload
//   wr_if         host write handshake (slave modport)
//   o_addr        port-B address
//   o_data        port-B write data
//   o_we          port-B write enable
//   o_configured  initial fill complete
//   o_err         sticky: illegal host write or illegal reload channel seen
//
// Build option:
//   CFG_REG_WRLOCK_EN  when defined, host writes to registers 0 and 1 are
//                      rejected as illegal; reloads still restore them.
// ---------------------------------------------------------------------------
module cfg_reg_bank_loader #(
    parameter int CHANNELS    = 2,
    parameter int REGS_PER_CH = 44,
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 25,
    parameter int CAM_LINE    = 9,
    parameter int CAM_PIXEL   = 10,
    parameter int CH_WIDTH    = 1,
    parameter int REG_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic                  i_reload,
    input  logic [CH_WIDTH-1:0]   i_reload_ch,
    cfg_reg_bank_loader_if.slave  wr_if,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_we,
    output logic                  o_configured,
    output logic                  o_err
);
    // Counter widths carry one spare bit so the terminal value
    // (total words, or words per channel) is representable.
    localparam int CW       = ADDR_WIDTH + 1;
    localparam int RW       = REG_WIDTH + 1;
    localparam int CHW1     = CH_WIDTH + 1;
    localparam int CH_SLOTS = 1 << CH_WIDTH;

    localparam logic [CW-1:0]   TOTAL_C     = CW'(CHANNELS * REGS_PER_CH);
    localparam logic [RW-1:0]   REGS_C      = RW'(REGS_PER_CH);
    localparam logic [RW-1:0]   REGS_LAST_C = RW'(REGS_PER_CH - 1);
    localparam logic [CHW1-1:0] CHANS_C     = CHW1'(CHANNELS);
    localparam logic [DATA_WIDTH-1:0] DEF_PIXEL = DATA_WIDTH'((2 ** CAM_PIXEL) - 1);
    localparam logic [DATA_WIDTH-1:0] DEF_LINE  = DATA_WIDTH'((2 ** CAM_LINE) - 1);

    typedef enum logic [1:0] {
        ST_INIT_ALL,
        ST_IDLE,
        ST_WRITE,
        ST_INIT_CH
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] def_word(input logic [RW-1:0] r);
        if (r == RW'(0)) begin
            return DEF_PIXEL;
        end else if (r == RW'(1)) begin
            return DEF_LINE;
        end else begin
            return '0;
        end
    endfunction

    // Base address of every channel slice; slots past CHANNELS are only
    // reachable through illegal indices, which are rejected before use.
    logic [ADDR_WIDTH-1:0] ch_base [CH_SLOTS];

    for (genvar gi = 0; gi < CH_SLOTS; gi++) begin : g_ch_base
        assign ch_base[gi] = ADDR_WIDTH'(gi * REGS_PER_CH);
    end

    state_t                state_q, state_d;
    logic [CW-1:0]         fill_cnt_q, fill_cnt_d;
    logic [RW-1:0]         reg_cnt_q, reg_cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  we_q, we_d;
    logic                  ready_q, ready_d;
    logic                  configured_q, configured_d;
    logic                  err_q, err_d;

    logic                  reload_ch_ok;
    logic                  host_ch_ok;
    logic                  host_reg_ok;
    logic                  host_ok;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [ADDR_WIDTH-1:0] reload_addr;

    assign reload_ch_ok = {1'b0, i_reload_ch} < CHANS_C;
    assign host_ch_ok   = {1'b0, wr_if.i_wr_ch} < CHANS_C;
    assign host_reg_ok  = {1'b0, wr_if.i_wr_reg} < REGS_C;

`ifdef CFG_REG_WRLOCK_EN
    // Geometry registers 0 and 1 are owned by the loader in this build.
    assign host_ok = host_ch_ok && host_reg_ok && ({1'b0, wr_if.i_wr_reg} >= RW'(2));
`else
    assign host_ok = host_ch_ok && host_reg_ok;
`endif

    assign host_addr   = ch_base[wr_if.i_wr_ch] + ADDR_WIDTH'(wr_if.i_wr_reg);
    assign reload_addr = base_q + ADDR_WIDTH'(reg_cnt_q);

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        reg_cnt_d    = reg_cnt_q;
        base_d       = base_q;
        addr_d       = addr_q;
        data_d       = data_q;
        we_d         = 1'b0;
        ready_d      = 1'b0;
        configured_d = configured_q;
        err_d        = err_q;

        case (state_q)
            ST_INIT_ALL: begin
                if (fill_cnt_q == TOTAL_C) begin
                    state_d      = ST_IDLE;
                    ready_d      = 1'b1;
                    configured_d = 1'b1;
                    reg_cnt_d    = '0;
                end else begin
                    we_d       = 1'b1;
                    addr_d     = fill_cnt_q[ADDR_WIDTH-1:0];
                    data_d     = def_word(reg_cnt_q);
                    fill_cnt_d = fill_cnt_q + CW'(1);
                    // reg_cnt_q tracks the register index inside the
                    // current channel so defaults need no division.
                    reg_cnt_d  = (reg_cnt_q == REGS_LAST_C) ? '0 : reg_cnt_q + RW'(1);
                end
            end

            ST_IDLE: begin
                ready_d = 1'b1;
                if (i_reload && !reload_ch_ok) begin
                    err_d = 1'b1;
                end
                if (i_reload && reload_ch_ok) begin
                    // First word of the slice goes out on the accepting edge.
                    state_d   = ST_INIT_CH;
                    ready_d   = 1'b0;
                    we_d      = 1'b1;
                    base_d    = ch_base[i_reload_ch];
                    addr_d    = ch_base[i_reload_ch];
                    data_d    = def_word('0);
                    reg_cnt_d = RW'(1);
                end else if (wr_if.i_wr_valid) begin
                    if (host_ok) begin
                        state_d = ST_WRITE;
                        ready_d = 1'b0;
                        we_d    = 1'b1;
                        addr_d  = host_addr;
                        data_d  = wr_if.i_wr_data;
                    end else begin
                        // Handshake still completes; the word is dropped.
                        err_d = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end

            ST_INIT_CH: begin
                if (reg_cnt_q == REGS_C) begin
                    state_d   = ST_IDLE;
                    ready_d   = 1'b1;
                    reg_cnt_d = '0;
                end else begin
                    we_d      = 1'b1;
                    addr_d    = reload_addr;
                    data_d    = def_word(reg_cnt_q);
                    reg_cnt_d = reg_cnt_q + RW'(1);
                end
            end

            default: begin
                state_d = ST_INIT_ALL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_INIT_ALL;
            fill_cnt_q   <= '0;
            reg_cnt_q    <= '0;
            base_q       <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            we_q         <= 1'b0;
            ready_q      <= 1'b0;
            configured_q <= 1'b0;
            err_q        <= 1'b0;
        end else if (i_enable) begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            reg_cnt_q    <= reg_cnt_d;
            base_q       <= base_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            we_q         <= we_d;
            ready_q      <= ready_d;
            configured_q <= configured_d;
            err_q        <= err_d;
        end
    end

    assign o_addr           = addr_q;
    assign o_data           = data_q;
    assign o_we             = we_q;
    assign o_configured     = configured_q;
    assign o_err            = err_q;
    assign wr_if.o_wr_ready = ready_q;
endmodule

// File: tb/tb_cfg_reg_bank_loader.sv
module tb_cfg_reg_bank_loader;
    localparam int CHANNELS    = 2;
    localparam int REGS_PER_CH = 44;
    localparam int ADDR_WIDTH  = 7;
    localparam int DATA_WIDTH  = 25;
    localparam int CAM_LINE    = 9;
    localparam int CAM_PIXEL   = 10;
    localparam int CH_WIDTH    = 1;
    localparam int REG_WIDTH   = 6;
    localparam int TOTAL       = CHANNELS * REGS_PER_CH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n = 1'b1;
    logic                  en;
    logic                  reload;
    logic [CH_WIDTH-1:0]   reload_ch;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_we;
    logic                  o_configured;
    logic                  o_err;

    cfg_reg_bank_loader_if #(
        .CH_WIDTH(CH_WIDTH), .REG_WIDTH(REG_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) wr_bus ();

    cfg_reg_bank_loader #(
        .CHANNELS(CHANNELS), .REGS_PER_CH(REGS_PER_CH), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .CAM_LINE(CAM_LINE), .CAM_PIXEL(CAM_PIXEL),
        .CH_WIDTH(CH_WIDTH), .REG_WIDTH(REG_WIDTH)
    ) dut (
        .clk(clk),
        .i_reset_n(rst_n),
        .i_enable(en),
        .i_reload(reload),
        .i_reload_ch(reload_ch),
        .wr_if(wr_bus),
        .o_addr(o_addr),
        .o_data(o_data),
        .o_we(o_we),
        .o_configured(o_configured),
        .o_err(o_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // The loader is modelled as a queue of pending port-B writes: every
    // enabled edge retires one queued write; an edge that finds the queue
    // empty leaves the loader idle and ready. Accepted requests append
    // their writes to the queue.
    int q_addr[$];
    int q_data[$];
    int exp_addr, exp_data;
    bit exp_we, exp_ready, exp_cfg, exp_err;

    function automatic int def_val(input int r);
        if (r == 0) return (1 << CAM_PIXEL) - 1;
        if (r == 1) return (1 << CAM_LINE) - 1;
        return 0;
    endfunction

    function automatic bit host_legal(input int ch, input int r);
        if (ch >= CHANNELS || r >= REGS_PER_CH) return 1'b0;
`ifdef CFG_REG_WRLOCK_EN
        if (r < 2) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic push_channel(input int ch);
        for (int r = 0; r < REGS_PER_CH; r++) begin
            q_addr.push_back(ch * REGS_PER_CH + r);
            q_data.push_back(def_val(r));
        end
    endtask

    task automatic model_reset();
        q_addr.delete();
        q_data.delete();
        for (int ch = 0; ch < CHANNELS; ch++) push_channel(ch);
        exp_addr = 0; exp_data = 0;
        exp_we = 0; exp_ready = 0; exp_cfg = 0; exp_err = 0;
    endtask

    task automatic model_step();
        bit took_reload;
        took_reload = 1'b0;
        if (exp_ready) begin
            if (reload) begin
                if (int'(reload_ch) < CHANNELS) begin
                    push_channel(int'(reload_ch));
                    took_reload = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (!took_reload && wr_bus.i_wr_valid) begin
                if (host_legal(int'(wr_bus.i_wr_ch), int'(wr_bus.i_wr_reg))) begin
                    q_addr.push_back(int'(wr_bus.i_wr_ch) * REGS_PER_CH + int'(wr_bus.i_wr_reg));
                    q_data.push_back(int'(wr_bus.i_wr_data));
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
        if (q_addr.size() > 0) begin
            exp_we    = 1'b1;
            exp_addr  = q_addr.pop_front();
            exp_data  = q_data.pop_front();
            exp_ready = 1'b0;
        end else begin
            exp_we    = 1'b0;
            exp_ready = 1'b1;
            exp_cfg   = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else if (en) model_step();
        end
    end

    // ---------------- compare + write log ----------------
    int seen_mem [128];
    int wlog[$];
    int we_cycles  = 0;
    int ready_low  = 0;

    initial begin
        forever begin
            @(negedge clk);
            chk("we", int'(o_we), int'(exp_we));
            chk("ready", int'(wr_bus.o_wr_ready), int'(exp_ready));
            chk("configured", int'(o_configured), int'(exp_cfg));
            chk("err", int'(o_err), int'(exp_err));
            if (exp_we) begin
                chk("addr", int'(o_addr), exp_addr);
                chk("data", int'(o_data), exp_data);
            end
            if (!rst_n) begin
                chk("addr_in_reset", int'(o_addr), 0);
                chk("data_in_reset", int'(o_data), 0);
            end
            if (o_we === 1'b1) begin
                seen_mem[o_addr] = int'(o_data);
                wlog.push_back(int'(o_addr));
                we_cycles++;
            end
            if (wr_bus.o_wr_ready !== 1'b1) ready_low++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic host_write(input int ch, input int r, input int data);
        bit rdy, done;
        done = 1'b0;
        wr_bus.i_wr_ch    = CH_WIDTH'(ch);
        wr_bus.i_wr_reg   = REG_WIDTH'(r);
        wr_bus.i_wr_data  = DATA_WIDTH'(data);
        wr_bus.i_wr_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            rdy = wr_bus.o_wr_ready;
            @(posedge clk);
            #2;
            if (rdy && en) done = 1'b1;
        end
        wr_bus.i_wr_valid = 1'b0;
        if (!done) chk("host_handshake_timeout", 0, 1);
        $display("host write ch=%0d reg=%0d data=0x%0h", ch, r, data);
    endtask

    task automatic do_reload(input int ch);
        reload    = 1'b1;
        reload_ch = CH_WIDTH'(ch);
        @(posedge clk);
        #2;
        reload = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wr_bus.o_wr_ready) break;
            @(posedge clk);
            #2;
        end
        $display("reload ch=%0d", ch);
    endtask

    task automatic wait_cfg(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(posedge clk);
            #2;
            if (o_configured) ok = 1'b1;
        end
        if (!ok) chk("configured_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_we", int'(o_we), 0);
        chk("rst_addr", int'(o_addr), 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_ready", int'(wr_bus.o_wr_ready), 0);
        chk("rst_configured", int'(o_configured), 0);
        chk("rst_err", int'(o_err), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        en = 1'b1;
        reload = 1'b0;
        reload_ch = '0;
        wr_bus.i_wr_valid = 1'b0;
        wr_bus.i_wr_ch    = '0;
        wr_bus.i_wr_reg   = '0;
        wr_bus.i_wr_data  = '0;
        for (int i = 0; i < 128; i++) seen_mem[i] = -1;

        // Initial fill
        #1 rst_n = 1'b0;
        @(posedge clk); #2;
        check_reset_outputs();
        @(posedge clk); #2;
        we_cycles = 0;
        wlog.delete();
        rst_n = 1'b1;
        wait_cfg(200);
        $display("initial fill: %0d writes", we_cycles);
        chk("fill_count", we_cycles, 88);
        chk("fill_first_addr", wlog[0], 0);
        chk("fill_last_addr", wlog[87], 87);
        chk("mem0", seen_mem[0], 'h3FF);
        chk("mem44", seen_mem[44], 'h3FF);
        chk("mem1", seen_mem[1], 'h1FF);
        chk("mem45", seen_mem[45], 'h1FF);
        chk("mem2", seen_mem[2], 0);
        chk("mem87", seen_mem[87], 0);

        // Legal host write
        we_cycles = 0;
        ready_low = 0;
        host_write(1, 5, 'h1ABCDE);
        repeat (3) @(posedge clk);
        #2;
        chk("hw_we_pulses", we_cycles, 1);
        chk("hw_mem49", seen_mem[49], 'h1ABCDE);
        chk("hw_ready_low", ready_low, 1);

        // Illegal register index
        we_cycles = 0;
        host_write(0, 44, 'h777);
        repeat (3) @(posedge clk);
        #2;
        chk("illegal_no_we", we_cycles, 0);
        chk("illegal_err", int'(o_err), 1);

        // Reload and host write requested on the same edge
        for (int i = 0; i < 44; i++) seen_mem[i] = -1;
        wlog.delete();
        reload = 1'b1;
        reload_ch = '0;
        wr_bus.i_wr_ch = '0;
        wr_bus.i_wr_reg = 6'd3;
        wr_bus.i_wr_data = 25'h55;
        wr_bus.i_wr_valid = 1'b1;
        @(posedge clk); #2;
        reload = 1'b0;
        $display("reload ch=0 with concurrent host write");
        host_write(0, 3, 'h55);
        repeat (3) @(posedge clk);
        #2;
        chk("reload_write_count", wlog.size(), 45);
        chk("reload_first", wlog[0], 0);
        chk("reload_last", wlog[43], 43);
        chk("reload_then_host", wlog[44], 3);
        chk("reload_mem0", seen_mem[0], 'h3FF);
        chk("reload_mem3", seen_mem[3], 'h55);
        chk("err_sticky", int'(o_err), 1);

        // Enable pulsing 1 in 4
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #2;
        en = 1'b0;
        we_cycles = 0;
        wlog.delete();
        for (int i = 0; i < 128; i++) seen_mem[i] = -1;
        rst_n = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #2;
            if (o_configured) break;
            en = (c % 4 == 3);
        end
        en = 1'b1;
        $display("pulsed-enable fill: %0d write clocks", we_cycles);
        chk("pulse_configured", int'(o_configured), 1);
        chk("pulse_we_clocks", we_cycles, 352);
        chk("pulse_mem0", seen_mem[0], 'h3FF);
        chk("pulse_mem45", seen_mem[45], 'h1FF);
        chk("pulse_mem87", seen_mem[87], 0);

        // Reset in the middle of the fill
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_we && o_addr == 7'd30) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset asserted during fill");
        check_reset_outputs();
        @(posedge clk); #2;
        wlog.delete();
        rst_n = 1'b1;
        wait_cfg(200);
        chk("refill_count", wlog.size(), 88);
        chk("refill_first", wlog[0], 0);

        // Write to geometry register 1 of channel 0
        we_cycles = 0;
        seen_mem[1] = -1;
        host_write(0, 1, 'h12345);
        repeat (3) @(posedge clk);
        #2;
`ifdef CFG_REG_WRLOCK_EN
        chk("lock_no_we", we_cycles, 0);
        chk("lock_err", int'(o_err), 1);
`else
        chk("unlocked_we", we_cycles, 1);
        chk("unlocked_mem1", seen_mem[1], 'h12345);
`endif

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 2) begin
                do_reload(int'($urandom_range(0, CHANNELS - 1)));
            end else begin
                host_write(int'($urandom_range(0, CHANNELS - 1)),
                           int'($urandom_range(0, 47)),
                           int'($urandom & 32'h01FF_FFFF));
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #2;
        end
        repeat (60) @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
